// File: rtl/ula_pkg.sv
// Shared definitions for the display scan blocks: scan mode encoding,
// blank-word default bit and a constant-foldable ceil(log2) helper.
`default_nettype none

package ula_pkg;

  typedef enum logic {
    MODE_AUTO   = 1'b0,
    MODE_MANUAL = 1'b1
  } scan_mode_e;

  // Replicated to WIDTH bits to form the default blank word.
  localparam logic BLANK_BIT = 1'b0;

  // ceil(log2(value)), never less than 1 so single-bit indices stay legal.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// Dwell prescaler: counts 0..PRESCALE-1 while run is high, clr forces 0.
`default_nettype none

module tick_gen
  import ula_pkg::*;
#(
  parameter int PRESCALE = 50000,
  localparam int CW = clog2(PRESCALE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          wrap
);

  assign wrap = (count == CW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_mux.sv
// Multiplexed display scanner: time-shares one output word across CHANNELS
// digits with per-channel blanking, anti-ghost dead time and manual select.
`default_nettype none

module display_scan_mux
  import ula_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 2,
  parameter logic [WIDTH-1:0] BLANK_VAL = {WIDTH{BLANK_BIT}},
  localparam int SEL_W = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS-1:0]       blank_mask,
  output logic [WIDTH-1:0]          Y,
  output logic [CHANNELS-1:0]       an_n,
  output logic [SEL_W-1:0]          sel,
  output logic                      frame_tick
);

  localparam int CW = clog2(PRESCALE);

  logic [CW-1:0]       count;
  logic                wrap;
  logic                manual;
  logic                run;
  logic                clr;
  logic                sel_ok;
  logic                blanked;
  logic                dead;
  logic [SEL_W-1:0]    ch;
  logic [SEL_W-1:0]    ch_eff;
  logic [WIDTH-1:0]    word;
  logic [CHANNELS-1:0] onehot;

  assign manual = (mode == MODE_MANUAL);
  assign run    = en & ~manual;
  assign clr    = en & manual;
  assign sel_ok = (32'(sel_in) < CHANNELS);

  // A valid manual select drives the outputs on the same edge it is loaded.
  assign ch_eff  = (clr && sel_ok) ? sel_in : ch;
  assign word    = D[int'(ch_eff) * WIDTH +: WIDTH];
  assign onehot  = CHANNELS'(1) << ch_eff;
  assign blanked = !en || (manual && !sel_ok) || blank_mask[ch_eff];
  assign dead    = !manual && (32'(count) < DEAD);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .clr  (clr),
    .count(count),
    .wrap (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch         <= '0;
      Y          <= BLANK_VAL;
      an_n       <= '1;
      sel        <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (run && wrap) begin
        ch <= (ch == SEL_W'(CHANNELS - 1)) ? '0 : ch + 1'b1;
      end else if (clr && sel_ok) begin
        ch <= sel_in;
      end
      Y          <= blanked ? BLANK_VAL : word;
      an_n       <= (blanked || dead) ? '1 : ~onehot;
      sel        <= ch_eff;
      frame_tick <= run && wrap && (ch == SEL_W'(CHANNELS - 1));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_scan_mux.sv
// Randomised self-checking bench for display_scan_mux against a dwell-time
// arithmetic model (4-channel build) plus a 3-channel build for invalid selects.
`default_nettype none

module tb_display_scan_mux;

  localparam int W  = 7;
  localparam int CH = 4;
  localparam int P  = 4;
  localparam int DT = 1;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          mode;
  logic [1:0]    sel_in;
  logic [27:0]   d;
  logic [3:0]    mask;
  logic [6:0]    y;
  logic [3:0]    an_n;
  logic [1:0]    sel;
  logic          ft;

  logic [1:0]    sel_in3;
  logic [20:0]   d3;
  logic [2:0]    mask3;
  logic [6:0]    y3;
  logic [2:0]    an3;
  logic [1:0]    sel3;
  logic          ft3;

  int checks;
  int failures;

  // Model state: channel at the dwell origin and enabled auto cycles since.
  int m_base;
  int m_t;
  logic [6:0] ey;
  logic [3:0] ean;
  logic [1:0] esel;
  logic       eft;

  display_scan_mux #(
    .WIDTH(W), .CHANNELS(CH), .PRESCALE(P), .DEAD(DT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
    .D(d), .blank_mask(mask), .Y(y), .an_n(an_n), .sel(sel), .frame_tick(ft)
  );

  display_scan_mux #(
    .WIDTH(W), .CHANNELS(3), .PRESCALE(P), .DEAD(DT)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in3),
    .D(d3), .blank_mask(mask3), .Y(y3), .an_n(an3), .sel(sel3), .frame_tick(ft3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cur_ch();
    return (m_base + m_t / P) % CH;
  endfunction

  // Predict this edge's outputs from the pre-edge inputs, then clock.
  task automatic step();
    int c;
    int pos;
    c    = cur_ch();
    pos  = m_t % P;
    ey   = 7'h00;
    ean  = 4'hF;
    esel = c[1:0];
    eft  = 1'b0;
    if (en) begin
      if (mode) begin
        c    = int'(sel_in);
        esel = c[1:0];
        if (!mask[c]) begin
          ey  = d[c*W +: W];
          ean = ~(4'b0001 << c);
        end
        m_base = c;
        m_t    = 0;
      end else begin
        if (!mask[c]) begin
          ey = d[c*W +: W];
          if (pos >= DT) ean = ~(4'b0001 << c);
        end
        eft = (pos == P-1) && (c == CH-1);
        m_t++;
        if (m_t >= P*CH) m_t -= P*CH;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_base = 0;
    m_t    = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_in = 2'd0; sel_in3 = 2'd0;
    d = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    d3 = {7'h5B, 7'h06, 7'h3F};
    mask = 4'b0; mask3 = 3'b0;
    #12;
    checks++;
    if ({y, an_n, sel, ft} !== {7'h00, 4'hF, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset: Y=%h an_n=%b sel=%0d ft=%b, required Y=00 an_n=1111 sel=0 ft=0",
               y, an_n, sel, ft);
    end
    checks++;
    if ({y3, an3, sel3, ft3} !== {7'h00, 3'b111, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset3: Y=%h an_n=%b sel=%0d ft=%b, required Y=00 an_n=111 sel=0 ft=0",
               y3, an3, sel3, ft3);
    end
    do_reset();
  endtask

  task automatic test_auto_scan();
    int ticks;
    ticks = 0;
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      ticks += int'(ft);
      checks++;
      if ({y, an_n, sel, ft} !== {ey, ean, esel, eft}) begin
        failures++;
        $display("FAIL auto[%0d]: Y=%h an_n=%b sel=%0d ft=%b, required Y=%h an_n=%b sel=%0d ft=%b",
                 i, y, an_n, sel, ft, ey, ean, esel, eft);
      end
    end
    checks++;
    if (ticks !== 2) begin
      failures++;
      $display("FAIL frame_tick_count: got %0d, required 2 in 32 cycles", ticks);
    end
  endtask

  task automatic test_blank_mask();
    mask = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({y, an_n, sel, ft} !== {ey, ean, esel, eft}) begin
        failures++;
        $display("FAIL blank[%0d]: Y=%h an_n=%b sel=%0d ft=%b, required Y=%h an_n=%b sel=%0d ft=%b",
                 i, y, an_n, sel, ft, ey, ean, esel, eft);
      end
    end
    mask = 4'b0;
  endtask

  task automatic test_enable_freeze();
    int guard;
    guard = 0;
    while (!(cur_ch() == 1 && m_t % P == 2) && guard < 64) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 64) begin
      failures++;
      $display("FAIL freeze_setup: model never reached channel 1 mid-dwell");
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({y, an_n, ft} !== {7'h00, 4'hF, 1'b0} || sel !== esel) begin
        failures++;
        $display("FAIL freeze[%0d]: Y=%h an_n=%b sel=%0d ft=%b, required Y=00 an_n=1111 sel=%0d ft=0",
                 i, y, an_n, sel, ft, esel);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({y, an_n, sel, ft} !== {ey, ean, esel, eft}) begin
        failures++;
        $display("FAIL resume[%0d]: Y=%h an_n=%b sel=%0d ft=%b, required Y=%h an_n=%b sel=%0d ft=%b",
                 i, y, an_n, sel, ft, ey, ean, esel, eft);
      end
    end
  endtask

  task automatic test_manual();
    mode = 1'b1; sel_in = 2'd3;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({y, an_n, sel, ft} !== {7'h4F, 4'b0111, 2'd3, 1'b0}) begin
        failures++;
        $display("FAIL manual3[%0d]: Y=%h an_n=%b sel=%0d ft=%b, required Y=4F an_n=0111 sel=3 ft=0",
                 i, y, an_n, sel, ft);
      end
    end
    sel_in = 2'd2;
    step();
    mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({y, an_n, sel, ft} !== {ey, ean, esel, eft}) begin
        failures++;
        $display("FAIL mode_return[%0d]: Y=%h an_n=%b sel=%0d ft=%b, required Y=%h an_n=%b sel=%0d ft=%b",
                 i, y, an_n, sel, ft, ey, ean, esel, eft);
      end
    end
    checks++;
    if ({y, an_n, sel} !== {7'h4F, 4'hF, 2'd3}) begin
      failures++;
      $display("FAIL mode_return_ch3: Y=%h an_n=%b sel=%0d, required Y=4F an_n=1111 sel=3",
               y, an_n, sel);
    end
  endtask

  task automatic test_manual_invalid();
    mode = 1'b1; sel_in = 2'd1; sel_in3 = 2'd1;
    step();
    checks++;
    if ({y3, an3, sel3, ft3} !== {7'h06, 3'b101, 2'd1, 1'b0}) begin
      failures++;
      $display("FAIL manual3ch_valid: Y=%h an_n=%b sel=%0d ft=%b, required Y=06 an_n=101 sel=1 ft=0",
               y3, an3, sel3, ft3);
    end
    sel_in3 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({y3, an3, sel3, ft3} !== {7'h00, 3'b111, 2'd1, 1'b0}) begin
        failures++;
        $display("FAIL manual3ch_invalid[%0d]: Y=%h an_n=%b sel=%0d ft=%b, required Y=00 an_n=111 sel=1 ft=0",
                 i, y3, an3, sel3, ft3);
      end
    end
    sel_in3 = 2'd0;
    mode = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (!(cur_ch() == 2 && m_t % P == 2) && guard < 64) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 64 || an_n !== 4'b1011) begin
      failures++;
      $display("FAIL async_setup: an_n=%b guard=%0d, required an_n=1011 on channel 2", an_n, guard);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({y, an_n, sel, ft} !== {7'h00, 4'hF, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: Y=%h an_n=%b sel=%0d ft=%b, required Y=00 an_n=1111 sel=0 ft=0",
               y, an_n, sel, ft);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    m_base = 0;
    m_t    = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({y, an_n, sel, ft} !== {ey, ean, esel, eft}) begin
        failures++;
        $display("FAIL restart[%0d]: Y=%h an_n=%b sel=%0d ft=%b, required Y=%h an_n=%b sel=%0d ft=%b",
                 i, y, an_n, sel, ft, ey, ean, esel, eft);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) d = 28'($urandom);
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
      step();
      checks++;
      if ({y, an_n, sel, ft} !== {ey, ean, esel, eft}) begin
        failures++;
        $display("FAIL random[%0d]: Y=%h an_n=%b sel=%0d ft=%b, required Y=%h an_n=%b sel=%0d ft=%b",
                 i, y, an_n, sel, ft, ey, ean, esel, eft);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_base   = 0;
    m_t      = 0;
    test_reset();
    test_auto_scan();
    test_blank_mask();
    test_enable_freeze();
    test_manual();
    test_manual_invalid();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
